fifo_b2s: RTL and testbench

Synchronous width-down FIFO, the counterpart of the 4-to-16 packing buffer on the other end of the nibble link. It accepts 16-bit words and emits them as 4-bit nibbles, most-significant nibble first. Single clock domain; sits between a 16-bit producer and a 4-bit serial-style consumer. Provides full, prog_full and empty flags, plus a write-overflow pulse.

---
 rtl/fifo_pkg.sv | 27 ++
 rtl/fifo_b2s_mem.sv | 23 ++
 rtl/fifo_b2s.sv | 76 +++++++
 tb/tb_fifo_b2s.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the 16-to-4 width-down FIFO.
package fifo_pkg;

    localparam int unsigned DIN_W        = 16;
    localparam int unsigned DOUT_W       = 4;
    localparam int unsigned RATIO        = DIN_W / DOUT_W;
    localparam int unsigned SEL_W        = $clog2(RATIO);
    localparam int unsigned DEPTH        = 8;
    localparam int unsigned PROG_FULL_TH = 6;
    localparam int unsigned ADDR_W       = $clog2(DEPTH);
    localparam int unsigned WPTR_W       = ADDR_W + 1;
    localparam int unsigned RPTR_W       = ADDR_W + SEL_W + 1;

    // Nibble select 0 is the most-significant nibble of the word.
    function automatic logic [DOUT_W-1:0] nib_sel(input logic [DIN_W-1:0] word,
                                                  input logic [SEL_W-1:0] sel);
        logic [DOUT_W-1:0] res;
        res = '0;
        for (int unsigned i = 0; i < RATIO; i++) begin
            if (sel == SEL_W'(i)) begin
                res = word[DIN_W-1-i*DOUT_W -: DOUT_W];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/fifo_b2s_mem.sv
// Word storage: synchronous write, combinational read, no reset.
module fifo_b2s_mem
    import fifo_pkg::*;
(
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DIN_W-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DIN_W-1:0]  rdata
);

    logic [DIN_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_b2s.sv
// Width-down FIFO: accepts DIN_W words, emits DOUT_W nibbles MS-first.
module fifo_b2s
    import fifo_pkg::*;
(
    input  logic              clk,
    input  logic              rstn,
    input  logic [DIN_W-1:0]  din,
    input  logic              din_en,
    output logic              full,
    output logic              prog_full,
    output logic              wr_err,
    input  logic              rinc,
    output logic [DOUT_W-1:0] dout,
    output logic              dout_en,
    output logic              empty
);

    logic [WPTR_W-1:0] wptr;
    logic [RPTR_W-1:0] rptr;
    logic [WPTR_W-1:0] rptr_word;
    logic [SEL_W-1:0]  sel;
    logic [WPTR_W-1:0] count;
    logic [DIN_W-1:0]  rdata;
    logic              wr_acc;
    logic              rd_acc;

    assign rptr_word = rptr[RPTR_W-1:SEL_W];
    assign sel       = rptr[SEL_W-1:0];
    assign count     = wptr - rptr_word;

    // Flags follow the pointers directly, so reset clears them asynchronously.
    assign full      = (count == WPTR_W'(DEPTH));
    assign prog_full = (count >= WPTR_W'(PROG_FULL_TH));
    assign empty     = (wptr == rptr_word) && (sel == '0);

    assign wr_acc = din_en && !full;
    assign rd_acc = rinc && !empty;

    fifo_b2s_mem u_mem (
        .clk   (clk),
        .we    (wr_acc),
        .waddr (wptr[ADDR_W-1:0]),
        .wdata (din),
        .raddr (rptr_word[ADDR_W-1:0]),
        .rdata (rdata)
    );

    // Write pointer and overflow pulse.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wptr   <= '0;
            wr_err <= 1'b0;
        end else begin
            wr_err <= din_en && full;
            if (wr_acc) begin
                wptr <= wptr + WPTR_W'(1);
            end
        end
    end

    // Read pointer and registered nibble output.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rptr    <= '0;
            dout    <= '0;
            dout_en <= 1'b0;
        end else begin
            dout_en <= rd_acc;
            if (rd_acc) begin
                dout <= nib_sel(rdata, sel);
                rptr <= rptr + RPTR_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_fifo_b2s.sv
// Directed self-checking bench for fifo_b2s.
module tb_fifo_b2s;
    import fifo_pkg::*;

    logic              clk;
    logic              rstn;
    logic [DIN_W-1:0]  din;
    logic              din_en;
    logic              full;
    logic              prog_full;
    logic              wr_err;
    logic              rinc;
    logic [DOUT_W-1:0] dout;
    logic              dout_en;
    logic              empty;

    int n_vec;
    int n_err;

    fifo_b2s dut (
        .clk       (clk),
        .rstn      (rstn),
        .din       (din),
        .din_en    (din_en),
        .full      (full),
        .prog_full (prog_full),
        .wr_err    (wr_err),
        .rinc      (rinc),
        .dout      (dout),
        .dout_en   (dout_en),
        .empty     (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] nib(input logic [15:0] w, input int i);
        return 4'(w >> (12 - 4 * i));
    endfunction

    logic [15:0] w [8];
    logic [15:0] x;
    logic [15:0] y;
    logic [3:0]  sb [$];
    logic [3:0]  e;
    int          wr_cnt;
    int          rd_cnt;
    logic        saw_full;

    initial begin
        n_vec  = 0;
        n_err  = 0;
        rstn   = 1'b0;
        din    = '0;
        din_en = 1'b0;
        rinc   = 1'b0;

        // 1. reset with random activity on inputs
        for (int i = 0; i < 3; i++) begin
            din  = 16'($urandom);
            rinc = 1'($urandom);
            step();
        end
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_pfull", 32'(prog_full), 32'd0);
        chk("rst_dout_en", 32'(dout_en), 32'd0);
        chk("rst_dout", 32'(dout), 32'd0);
        rinc = 1'b0;
        rstn = 1'b1;
        step();
        chk("post_rst_empty", 32'(empty), 32'd1);
        chk("post_rst_full", 32'(full), 32'd0);
        chk("post_rst_pfull", 32'(prog_full), 32'd0);

        // 2. single word 4321 -> 4,3,2,1
        din    = 16'h4321;
        din_en = 1'b1;
        step();
        din_en = 1'b0;
        chk("w1_not_empty", 32'(empty), 32'd0);
        rinc = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("w1_dout_en", 32'(dout_en), 32'd1);
            chk("w1_dout", 32'(dout), 32'(4 - i));
        end
        chk("w1_empty", 32'(empty), 32'd1);
        step();
        chk("w1_extra_en", 32'(dout_en), 32'd0);
        chk("w1_extra_hold", 32'(dout), 32'd1);
        rinc = 1'b0;

        // 3. fill to full, overflow, drain
        for (int i = 0; i < 8; i++) begin
            w[i]   = 16'($urandom);
            din    = w[i];
            din_en = 1'b1;
            step();
            chk("fill_pfull", 32'(prog_full), (i + 1 >= 6) ? 32'd1 : 32'd0);
            chk("fill_full", 32'(full), (i == 7) ? 32'd1 : 32'd0);
        end
        din = 16'($urandom);
        step();
        chk("ovf_err", 32'(wr_err), 32'd1);
        din_en = 1'b0;
        step();
        chk("ovf_err_pulse", 32'(wr_err), 32'd0);
        chk("ovf_still_full", 32'(full), 32'd1);
        rinc = 1'b1;
        for (int i = 0; i < 32; i++) begin
            step();
            chk("fill_dout_en", 32'(dout_en), 32'd1);
            chk("fill_dout", 32'(dout), 32'(nib(w[i / 4], i % 4)));
        end
        rinc = 1'b0;
        chk("fill_drained", 32'(empty), 32'd1);

        // 4. full boundary: write dropped while a word is being freed
        din_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            w[i] = 16'($urandom);
            din  = w[i];
            step();
        end
        din_en = 1'b0;
        chk("bnd_full", 32'(full), 32'd1);
        rinc = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("bnd_dout", 32'(dout), 32'(nib(w[0], i)));
            chk("bnd_full_hold", 32'(full), 32'd1);
        end
        x      = ~w[0];
        din    = x;
        din_en = 1'b1;
        step();
        chk("bnd_dout3", 32'(dout), 32'(nib(w[0], 3)));
        chk("bnd_full_fall", 32'(full), 32'd0);
        chk("bnd_err", 32'(wr_err), 32'd1);
        rinc = 1'b0;
        y    = 16'($urandom);
        din  = y;
        step();
        din_en = 1'b0;
        chk("bnd_refull", 32'(full), 32'd1);
        chk("bnd_err_clr", 32'(wr_err), 32'd0);
        rinc = 1'b1;
        for (int i = 0; i < 32; i++) begin
            step();
            e = (i < 28) ? nib(w[1 + i / 4], i % 4) : nib(y, i % 4);
            chk("bnd_drain", 32'(dout), 32'(e));
        end
        rinc = 1'b0;
        chk("bnd_empty", 32'(empty), 32'd1);

        // 5. streaming with wrap, scoreboard check
        wr_cnt   = 0;
        rd_cnt   = 0;
        saw_full = 1'b0;
        for (int cyc = 0; cyc < 600 && rd_cnt < 400; cyc++) begin
            din_en = (cyc % 4 == 0) && (wr_cnt < 100);
            rinc   = !empty;
            if (din_en) begin
                din = 16'($urandom);
                if (!full) begin
                    for (int i = 0; i < 4; i++) sb.push_back(nib(din, i));
                    wr_cnt++;
                end
            end
            step();
            if (full) saw_full = 1'b1;
            if (dout_en) begin
                e = (sb.size() > 0) ? sb.pop_front() : 4'hx;
                chk("stream_dout", 32'(dout), 32'(e));
                rd_cnt++;
            end
        end
        din_en = 1'b0;
        rinc   = 1'b0;
        chk("stream_count", 32'(rd_cnt), 32'd400);
        chk("stream_no_full", 32'(saw_full), 32'd0);

        // 6. asynchronous reset mid-operation
        din_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            din = 16'($urandom);
            step();
        end
        din_en = 1'b0;
        rinc   = 1'b1;
        step();
        step();
        rinc = 1'b0;
        chk("mid_dout_en", 32'(dout_en), 32'd1);
        rstn = 1'b0;
        #1;
        chk("mid_rst_empty", 32'(empty), 32'd1);
        chk("mid_rst_dout_en", 32'(dout_en), 32'd0);
        chk("mid_rst_full", 32'(full), 32'd0);
        #9;
        rstn = 1'b1;
        step();
        chk("after_rst_empty", 32'(empty), 32'd1);
        din    = 16'hA5C3;
        din_en = 1'b1;
        step();
        din_en = 1'b0;
        rinc   = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("a5c3_dout", 32'(dout), 32'(nib(16'hA5C3, i)));
        end
        rinc = 1'b0;
        step();
        chk("a5c3_empty", 32'(empty), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
